// File: rtl/aes_pkg.sv
// Shared AES definitions: state/column/byte types, the forward S-box table and
// byte/column slicing helpers used by the round-stage blocks.
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_COL_W   = 32;

   typedef logic [AES_STATE_W-1:0] state_t;
   typedef logic [AES_COL_W-1:0]   col_t;
   typedef logic [7:0]             byte_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } sbi_state_e;

   localparam byte_t SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Byte k lives at bits [8k+7:8k]; column c is bytes 4c..4c+3.
   function automatic byte_t get_byte(input state_t s, input int k);
      return s[8*k +: 8];
   endfunction

   function automatic col_t get_col(input state_t s, input int c);
      return s[AES_COL_W*c +: AES_COL_W];
   endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle between the SubBytes stage, its producer and its consumer.
interface sub_bytes_iter_if;
   import aes_pkg::*;

   // A word moves on a rising clk edge where valid && ready; valid while ready=0
   // is simply ignored (nothing is queued), and data is sampled only on that edge.
   logic   in_valid;
   logic   in_ready;
   state_t in_data;
   logic   out_valid;
   logic   out_ready;
   state_t out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a pure combinational lookup; shared with key expansion.
module aes_sbox
   import aes_pkg::*;
(
   input  byte_t din,
   output byte_t dout
);

   assign dout = SBOX_FWD[din];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: substitutes COLS_PER_CYCLE columns per clock in place in a
// 128-bit buffer, then holds the result until the consumer takes it.
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   sub_bytes_iter_if.slave bus,
   output sbi_state_e      dbg_state
);

   localparam int NCYC = 4 / COLS_PER_CYCLE;
   localparam int NSB  = 4 * COLS_PER_CYCLE;
   localparam int WIN  = AES_COL_W * COLS_PER_CYCLE;
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("sub_bytes_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   sbi_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   state_t          buf_q, buf_d;
   logic [WIN-1:0]  win, win_sub;
   int unsigned     base;
   logic            last;
   logic            in_ready_c;
   logic            out_valid_c;

   assign base = WIN * int'(cnt_q);
   assign win  = buf_q[base +: WIN];
   assign last = (cnt_q == CW'(NCYC - 1));

   for (genvar i = 0; i < NSB; i++) begin : g_sbox
      aes_sbox u_sbox (
         .din  (win[8*i +: 8]),
         .dout (win_sub[8*i +: 8])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               buf_d   = bus.in_data;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            buf_d[base +: WIN] = win_sub;
            if (last) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            out_valid_c = 1'b1;
            // Handing off frees the buffer on the same edge, so a new state may enter.
            in_ready_c  = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  buf_d   = bus.in_data;
                  cnt_d   = '0;
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = buf_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: directed and random traffic against an S-box model
// derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_iter;
   import aes_pkg::*;

   logic clk;
   logic rst_n;
   sbi_state_e d1, d2, d4;

   sub_bytes_iter_if b1 ();
   sub_bytes_iter_if b2 ();
   sub_bytes_iter_if b4 ();

   sub_bytes_iter #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(d1));
   sub_bytes_iter #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .dbg_state(d2));
   sub_bytes_iter #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4), .dbg_state(d4));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q[$];

   logic   s_acc1, s_ov1, s_ir1, s_ov2, s_ov4;
   state_t s_od1, s_od2, s_od4;

   // reference model
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      if (a == 8'h00) return 8'h00;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] b = ginv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_ref(input logic [127:0] s);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref(s[8*k +: 8]);
      return r;
   endfunction

   // scoreboard compare
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver: sample pre-edge, update scoreboard for u_dut1, advance one clock
   task automatic tick();
      logic [127:0] e;
      #1;
      s_acc1 = b1.in_valid && b1.in_ready;
      s_ov1  = b1.out_valid;
      s_ir1  = b1.in_ready;
      s_od1  = b1.out_data;
      s_ov2  = b2.out_valid;
      s_od2  = b2.out_data;
      s_ov4  = b4.out_valid;
      s_od4  = b4.out_data;
      if (s_acc1) exp_q.push_back(sub_ref(b1.in_data));
      if (b1.out_valid && b1.out_ready) begin
         chk("sb_expected_pending", 128'(exp_q.size() > 0), 128'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_data", s_od1, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input state_t d, output int lat);
      logic acc = 1'b0;
      lat = -1;
      b1.in_valid = 1'b1;
      b1.in_data  = d;
      for (int k = 0; k < 20 && !acc; k++) begin
         tick();
         acc = s_acc1;
      end
      chk("send_accept", 128'(acc), 128'(1));
      b1.in_valid = 1'b0;
      b1.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int k = 0; k < 20 && lat < 0; k++) begin
         tick();
         if (s_ov1) lat = k;
      end
   endtask

   localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
   localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
   localparam logic [127:0] POS_IN   = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] POS_OUT  = 128'h76abd7fe2b670130c56f6bf27b777c63;

   initial begin
      int lat, lat1, lat2, lat4, last_t, blk;
      logic toggle;
      state_t d, held;

      b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 1;
      b2.in_valid = 0; b2.in_data = '0; b2.out_ready = 1;
      b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 1;
      rst_n = 1'b0;

      // reset state
      #1;
      chk("rst_out_valid", 128'(b1.out_valid), 128'(0));
      chk("rst_out_data", b1.out_data, 128'h0);
      chk("rst_in_ready", 128'(b1.in_ready), 128'(1));
      chk("rst_state", 128'(d1), 128'(ST_IDLE));
      chk("rst_in_ready_c4", 128'(b4.in_ready), 128'(1));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 round-1 vector on all three widths at once
      b1.in_valid = 1; b1.in_data = FIPS_IN;
      b2.in_valid = 1; b2.in_data = FIPS_IN;
      b4.in_valid = 1; b4.in_data = FIPS_IN;
      tick();
      chk("fips_accept", 128'(s_acc1), 128'(1));
      b1.in_valid = 0; b2.in_valid = 0; b4.in_valid = 0;
      b1.in_data = '1; b2.in_data = '1; b4.in_data = '1;
      lat1 = -1; lat2 = -1; lat4 = -1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (s_ov1 && lat1 < 0) begin lat1 = k; chk("fips_data_c1", s_od1, FIPS_OUT); end
         if (s_ov2 && lat2 < 0) begin lat2 = k; chk("fips_data_c2", s_od2, FIPS_OUT); end
         if (s_ov4 && lat4 < 0) begin lat4 = k; chk("fips_data_c4", s_od4, FIPS_OUT); end
      end
      chk("fips_lat_c1", 128'(lat1), 128'(4));
      chk("fips_lat_c2", 128'(lat2), 128'(2));
      chk("fips_lat_c4", 128'(lat4), 128'(1));

      // all-zero state, then out_valid drops and in_ready returns
      send1(128'h0, lat);
      chk("zero_lat", 128'(lat), 128'(4));
      chk("zero_data", s_od1, {16{8'h63}});
      tick();
      chk("zero_valid_drop", 128'(s_ov1), 128'(0));
      chk("zero_in_ready", 128'(s_ir1), 128'(1));

      // byte-position mapping
      send1(POS_IN, lat);
      chk("pos_lat", 128'(lat), 128'(4));
      chk("pos_data", s_od1, POS_OUT);

      // backpressure: hold the result, refuse a new state, accept on release
      b1.out_ready = 0;
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      send1(d, lat);
      chk("bp_lat", 128'(lat), 128'(4));
      held = s_od1;
      chk("bp_data", held, sub_ref(d));
      b1.in_valid = 1; b1.in_data = '1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("bp_valid", 128'(s_ov1), 128'(1));
         chk("bp_stable", s_od1, held);
         chk("bp_in_ready", 128'(s_ir1), 128'(0));
      end
      b1.out_ready = 1;
      tick();
      chk("bp_release_accept", 128'(s_acc1), 128'(1));
      b1.in_valid = 0;
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         tick();
         if (s_ov1) lat = k;
      end
      chk("bp_second_lat", 128'(lat), 128'(4));
      chk("bp_second_data", s_od1, {16{8'h16}});

      // back-to-back with both sides always ready
      b1.in_valid = 1; b1.in_data = {16{8'h53}};
      toggle = 1'b0; last_t = -1; blk = 0;
      for (int t = 0; t < 50; t++) begin
         tick();
         if (s_ov1) begin
            chk("b2b_data", s_od1, (blk % 2 == 0) ? {16{8'hed}} : {16{8'h7c}});
            if (last_t >= 0) chk("b2b_gap", 128'(t - last_t), 128'(5));
            last_t = t;
            blk++;
         end
         if (s_acc1) begin
            toggle = ~toggle;
            b1.in_data = toggle ? {16{8'h01}} : {16{8'h53}};
         end
      end
      chk("b2b_count", 128'(blk), 128'(9));
      b1.in_valid = 0;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
      chk("b2b_drained", 128'(exp_q.size()), 128'(0));
      tick();

      // reset during the second BUSY cycle
      b1.in_valid = 1; b1.in_data = {16{8'haa}};
      tick();
      chk("rst_mid_accept", 128'(s_acc1), 128'(1));
      b1.in_valid = 0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 128'(b1.out_valid), 128'(0));
      chk("rst_mid_out_data", b1.out_data, 128'h0);
      chk("rst_mid_in_ready", 128'(b1.in_ready), 128'(1));
      chk("rst_mid_state", 128'(d1), 128'(ST_IDLE));
      exp_q.delete();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      send1(128'h0, lat);
      chk("rst_after_lat", 128'(lat), 128'(4));
      chk("rst_after_data", s_od1, {16{8'h63}});

      // random traffic with random consumer stalls
      for (int t = 0; t < 300; t++) begin
         b1.in_valid  = 1'($urandom_range(0, 1));
         b1.in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
         b1.out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      b1.in_valid = 0; b1.out_ready = 1;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
      chk("rand_drained", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Iterative AES SubBytes round stage.
- Accepts a 128-bit state through a valid/ready handshake and substitutes COLS_PER_CYCLE 32-bit columns per clock through shared S-box instances.
- Holds the 128-bit result until the consumer takes it.
- Sits directly upstream of shift_rows and drives its 128-bit input; trades latency for S-box area, since only 4*COLS_PER_CYCLE S-boxes are built instead of 16.

Parameters:
- COLS_PER_CYCLE, 1, columns substituted per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data holds a state to be substituted
- in_ready  output  1  block can accept a state this cycle
- in_data  input  128  input state; byte k at bits [8k+7:8k], column c = bytes 4c..4c+3
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  128  substituted state, same byte mapping; registered

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, column counter=0, internal buffer=0.
  - out_valid=0, out_data=128'h0.
  - in_ready=1 as soon as rst_n is low; it is combinational from state.
- Constant: NCYC = 4/COLS_PER_CYCLE.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into the buffer, counter=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, columns counter*C .. counter*C+C-1 of the buffer go through S-box and are written in place; counter increments.
  - After the write with counter=NCYC-1, go to DONE; the counter wraps to 0.
- DONE:
  - out_valid=1; out_data equals the buffer and is stable while out_ready=0.
  - in_ready = out_ready. This is combinational and is the only comb path from input to output.
  - out_ready=1, in_valid=0: go to IDLE, out_valid drops the next cycle.
  - out_ready=1, in_valid=1: result handed off and new state latched on the same edge; go to BUSY.
- Latency: accept on edge N -> out_valid=1 in the cycle after edge N+NCYC.
- Throughput: one block per NCYC+1 cycles when both sides are always ready.
- in_valid is ignored whenever in_ready=0; no queueing.
- in_data is sampled only on the accept edge and may change freely afterwards.
- out_data keeps its last value after handoff; it is only valid while out_valid=1.
- Reset asserted mid-BUSY or mid-DONE: the operation is discarded and the result is never presented; the first accept after release behaves exactly as after power-up.
- S-box: the FIPS-197 forward S-box, purely combinational, with no registers inside.

Decomposition:
- aes_pkg (shared package):
  - AES_STATE_W=128, AES_COL_W=32.
  - typedefs state_t, col_t, byte_t.
  - 256-entry forward S-box constant table.
  - byte/column index helper functions.
  - The later inverse S-box table also goes here.
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational table lookup.
  - sub_bytes_iter instantiates 4*COLS_PER_CYCLE copies.
  - The same module is reused by the key-expansion block.
- FSM, counter, buffer and handshake stay in sub_bytes_iter.

Test Plan:
- All-zero state, C=1, out_ready=1:
  - Send in_data=128'h0 -> out_valid rises 4 cycles after accept with out_data=128'h6363..63 (all bytes 0x63).
  - Then in_ready returns to 1.
- FIPS-197 App. B round-1 vector:
  - in_data=128'h0848f8e92a8dc69a2be2f4a0bee33d19 -> out_data=128'h3052411ee55db4b8f198bfe0ae1127d4.
  - Repeat for C=1, 2 and 4; latency must be 4, 2 and 1 cycles respectively.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> out_data stable and out_valid=1.
  - in_ready=0; a second in_valid pulse with 128'hff..ff is not accepted.
  - Raise out_ready -> the queued input is accepted on that same edge and later yields all bytes 0x16.
- Back-to-back, C=1:
  - in_valid and out_ready tied 1, inputs alternating all-0x53 / all-0x01 -> results all-0xed / all-0x7c.
  - Exactly one out_valid cycle per 5 clocks; no block dropped or duplicated.
- Reset mid-operation:
  - Drop rst_n during the 2nd BUSY cycle -> out_valid=0, out_data=0 and in_ready=1 before the next clock edge.
  - After release, in_data=128'h0 gives all 0x63 at the correct latency.
- Byte-position check:
  - in_data byte k = k for k=0..15 -> out byte k = S(k): 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76.
  - This confirms the column-to-bit mapping matches what shift_rows expects.
